// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package prefetch_pkg;

    localparam int ADDR_W  = 23;
    localparam int LADDR_W = 22;
    localparam int INS_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] PTR_INC = 23'd2;

endpackage

// File: rtl/fa23.sv
// 23-bit adder; the carry out of bit 22 is dropped, so sums wrap mod 2^23.
module fa23 (
    input  logic [22:0] a,
    input  logic [22:0] b,
    output logic [22:0] s
);

    assign s = a + b;

endmodule

// File: rtl/prefetch_fifo.sv
// Circular instruction buffer: 0/1/2 pushes and 0/1 pop per cycle, with flush.
// GPU_PREFETCH_PC_OUT_EN adds a per-entry halfword address alongside the data.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [1:0]        push_n,
    input  logic [INS_W-1:0]  push_d0,
    input  logic [INS_W-1:0]  push_d1,
`ifdef GPU_PREFETCH_PC_OUT_EN
    input  logic [ADDR_W-1:0] push_a0,
    input  logic [ADDR_W-1:0] push_a1,
    output logic [ADDR_W-1:0] head_a,
`endif
    input  logic              pop,
    output logic              head_valid,
    output logic [INS_W-1:0]  head_d,
    output logic [CW-1:0]     count
);

    logic [INS_W-1:0]  mem_q [DEPTH];
`ifdef GPU_PREFETCH_PC_OUT_EN
    logic [ADDR_W-1:0] amem_q [DEPTH];
`endif
    logic [AW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     cnt_q;
    logic              do_pop;

    assign head_valid = (cnt_q != '0);
    assign do_pop     = pop & head_valid;
    assign count      = cnt_q;
    // Empty reads as zero so nothing stale leaks out after reset or flush.
    assign head_d     = head_valid ? mem_q[rd_q] : '0;
`ifdef GPU_PREFETCH_PC_OUT_EN
    assign head_a     = head_valid ? amem_q[rd_q] : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_n);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + CW'(push_n) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            if (push_n != 2'd0) begin
                mem_q[wr_q] <= push_d0;
`ifdef GPU_PREFETCH_PC_OUT_EN
                amem_q[wr_q] <= push_a0;
`endif
            end
            if (push_n == 2'd2) begin
                mem_q[wr_q + AW'(1)] <= push_d1;
`ifdef GPU_PREFETCH_PC_OUT_EN
                amem_q[wr_q + AW'(1)] <= push_a1;
`endif
            end
        end
    end

endmodule

// File: rtl/gpu_prefetch_queue.sv
// Instruction prefetch: longword reads, big-endian halfword unpack, queued issue.
// GPU_PREFETCH_PC_OUT_EN adds ins_pc, the halfword address of the head entry.
module gpu_prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               sys_clk,
    input  logic               resetl,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               req,
    output logic [LADDR_W-1:0] req_addr,
    input  logic               ack,
    input  logic               rdata_valid,
    input  logic [31:0]        rdata,
    output logic               ins_valid,
    output logic [INS_W-1:0]   ins_data,
    input  logic               ins_ready,
`ifdef GPU_PREFETCH_PC_OUT_EN
    output logic [ADDR_W-1:0]  ins_pc,
`endif
    output logic               busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic              skip_q, skip_d;
    logic              discard_q, discard_d;
    logic [CW-1:0]     count;
    logic              in_req, in_wait, acked, data_in, issue, push_ok, pop;
    logic [1:0]        push_n;
    logic [INS_W-1:0]  push_d0;

    fa23 u_inc (
        .a (ptr_q & ~ADDR_W'(1)),
        .b (PTR_INC),
        .s (ptr_inc)
    );

`ifdef GPU_PREFETCH_PC_OUT_EN
    // Longword address of the in-flight request; ptr_q has already moved on.
    logic [LADDR_W-1:0] laddr_q, laddr_d;
    logic [ADDR_W-1:0]  push_a0;

    assign push_a0 = skip_q ? {laddr_q, 1'b1} : {laddr_q, 1'b0};
`endif

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (sys_clk),
        .rst_n      (resetl),
        .flush      (jump),
        .push_n     (push_n),
        .push_d0    (push_d0),
        .push_d1    (rdata[15:0]),
`ifdef GPU_PREFETCH_PC_OUT_EN
        .push_a0    (push_a0),
        .push_a1    ({laddr_q, 1'b1}),
        .head_a     (ins_pc),
`endif
        .pop        (pop),
        .head_valid (ins_valid),
        .head_d     (ins_data),
        .count      (count)
    );

    always_comb begin
        in_req   = (state_q == REQ);
        in_wait  = (state_q == WAIT);
        acked    = in_req & ack;
        data_in  = in_wait & rdata_valid;
        issue    = (state_q == IDLE) && (count <= CW'(DEPTH - 2)) && !jump && !discard_q;
        push_ok  = data_in & ~discard_q & ~jump;
        push_n   = push_ok ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
        push_d0  = skip_q ? rdata[15:0] : rdata[31:16];
        pop      = ins_ready & ~jump;

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (issue)   state_d = REQ;
            REQ:     if (ack)     state_d = WAIT;
            WAIT:    if (data_in) state_d = IDLE;
            default:              state_d = IDLE;
        endcase

        ptr_d = ptr_q;
        if (jump)       ptr_d = jump_addr & ~ADDR_W'(1);
        else if (acked) ptr_d = ptr_inc;

        skip_d = skip_q;
        if (jump)                 skip_d = jump_addr[0];
        else if (push_ok)         skip_d = 1'b0;

        // A jump with the response already on the bus needs no discard.
        discard_d = discard_q;
        if (jump)         discard_d = in_req | (in_wait & ~rdata_valid);
        else if (data_in) discard_d = 1'b0;

`ifdef GPU_PREFETCH_PC_OUT_EN
        laddr_d = acked ? ptr_q[ADDR_W-1:1] : laddr_q;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            skip_q    <= 1'b0;
            discard_q <= 1'b0;
`ifdef GPU_PREFETCH_PC_OUT_EN
            laddr_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            skip_q    <= skip_d;
            discard_q <= discard_d;
`ifdef GPU_PREFETCH_PC_OUT_EN
            laddr_q   <= laddr_d;
`endif
        end
    end

    assign req      = in_req;
    assign req_addr = ptr_q[ADDR_W-1:1];
    assign busy     = (state_q != IDLE) | discard_q;

endmodule

// File: tb/tb_gpu_prefetch_queue.sv
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_gpu_prefetch_queue;

    localparam int DEPTH = 8;

    logic        sys_clk = 1'b0;
    logic        resetl = 1'b0, jump = 1'b0, ack = 1'b0, rdata_valid = 1'b0, ins_ready = 1'b0;
    logic [22:0] jump_addr = '0;
    logic [31:0] rdata = '0;
    logic        req, ins_valid, busy;
    logic [21:0] req_addr;
    logic [15:0] ins_data;
`ifdef GPU_PREFETCH_PC_OUT_EN
    logic [22:0] ins_pc;
`endif

    always #5 sys_clk = ~sys_clk;

    gpu_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .sys_clk     (sys_clk),
        .resetl      (resetl),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .req         (req),
        .req_addr    (req_addr),
        .ack         (ack),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_ready   (ins_ready),
`ifdef GPU_PREFETCH_PC_OUT_EN
        .ins_pc      (ins_pc),
`endif
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of (instruction, address) plus request bookkeeping.
    typedef struct { logic [15:0] d; logic [22:0] pc; } ent_t;
    ent_t        mq[$];
    logic [22:0] m_ptr = '0, m_base = '0;
    bit          m_skip = 0, m_disc = 0, m_reqing = 0, m_waiting = 0;

    task automatic model_step(input bit rst, input bit j, input logic [22:0] ja, input bit a,
                              input bit rv, input logic [31:0] rd, input bit rdy);
        bit arrive, acked, issue;
        if (!rst) begin
            mq.delete();
            m_ptr = '0; m_base = '0;
            m_skip = 0; m_disc = 0; m_reqing = 0; m_waiting = 0;
            return;
        end
        arrive = m_waiting && rv;
        acked  = m_reqing && a;
        issue  = !m_reqing && !m_waiting && (mq.size() <= DEPTH - 2) && !j && !m_disc;
        if (j) begin
            mq.delete();
            m_disc = m_reqing || (m_waiting && !rv);
            m_skip = ja[0];
            m_ptr  = {ja[22:1], 1'b0};
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (arrive) begin
                if (!m_disc) begin
                    if (!m_skip) mq.push_back('{rd[31:16], m_base});
                    mq.push_back('{rd[15:0], m_base + 23'd1});
                    m_skip = 0;
                end
                m_disc = 0;
            end
            if (acked) begin
                m_base = m_ptr;
                m_ptr  = m_ptr + 23'd2;
            end
        end
        if (acked) begin m_reqing = 0; m_waiting = 1; end
        if (arrive) m_waiting = 0;
        if (issue) m_reqing = 1;
    endtask

    task automatic compare();
        chk("req", req, m_reqing);
        chk("req_addr", req_addr, m_ptr[22:1]);
        chk("ins_valid", ins_valid, mq.size() > 0);
        chk("ins_data", ins_data, (mq.size() > 0) ? mq[0].d : 16'h0);
        chk("busy", busy, m_reqing || m_waiting || m_disc);
`ifdef GPU_PREFETCH_PC_OUT_EN
        chk("ins_pc", ins_pc, (mq.size() > 0) ? mq[0].pc : 23'h0);
`endif
    endtask

    task automatic cyc(input bit rst, input bit j, input logic [22:0] ja, input bit a,
                       input bit rv, input logic [31:0] rd, input bit rdy);
        resetl = rst; jump = j; jump_addr = ja; ack = a;
        rdata_valid = rv; rdata = rd; ins_ready = rdy;
        @(posedge sys_clk);
        model_step(rst, j, ja, a, rv, rd, rdy);
        #1;
        compare();
    endtask

    task automatic idle();                      cyc(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_rst();                    cyc(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_jump(input logic [22:0] x); cyc(1, 1, x, 0, 0, 0, 0); endtask
    task automatic do_ack();                    cyc(1, 0, 0, 1, 0, 0, 0); endtask
    task automatic do_data(input logic [31:0] d); cyc(1, 0, 0, 0, 1, d, 0); endtask
    task automatic do_pop();                    cyc(1, 0, 0, 0, 0, 0, 1); endtask

    initial begin
        // Reset state and basic fetch with minimum latency.
        do_rst();
        chk("rst_req", req, 0);
        chk("rst_valid", ins_valid, 0);
        chk("rst_data", ins_data, 0);
        chk("rst_busy", busy, 0);
        do_jump(23'h000100);
        idle();
        chk("t1_req_addr0", req_addr, 22'h000080);
        do_ack();
        chk("t1_no_valid_yet", ins_valid, 0);
        do_data(32'h11112222);
        chk("t1_first", ins_data, 16'h1111);
        do_pop();
        chk("t1_second", ins_data, 16'h2222);
        chk("t1_req_addr1", req_addr, 22'h000081);

        // Odd jump target keeps only the odd halfword.
        do_rst();
        do_jump(23'h000101);
        idle();
        do_ack();
        do_data(32'hAAAABBBB);
        chk("t2_odd", ins_data, 16'hBBBB);
`ifdef GPU_PREFETCH_PC_OUT_EN
        chk("t2_pc", ins_pc, 23'h000101);
`endif
        do_pop();
        chk("t2_empty", ins_valid, 0);

        // Fill to DEPTH with the decoder stalled; issue resumes at 2 free slots.
        do_rst();
        do_jump(23'h0);
        for (int k = 0; k < 4; k++) begin
            idle();
            do_ack();
            do_data(32'h10002000 + k);
        end
        idle();
        chk("t3_full_noreq", req, 0);
        do_pop();
        idle();
        chk("t3_7_noreq", req, 0);
        do_pop();
        idle();
        chk("t3_6_req", req, 1);

        // Jump while waiting: response is dropped, busy holds until it lands.
        do_rst();
        do_jump(23'h0);
        idle();
        do_ack();
        do_jump(23'h000200);
        chk("t4_busy0", busy, 1);
        idle();
        chk("t4_busy1", busy, 1);
        chk("t4_noreq", req, 0);
        do_data(32'hDEADBEEF);
        chk("t4_dropped", ins_valid, 0);
        chk("t4_idle", busy, 0);
        idle();
        chk("t4_req_addr", req_addr, 22'h000100);

        // Pointer wrap at the top of the address space.
        do_rst();
        do_jump(23'h7FFFFE);
        idle();
        chk("t5_top", req_addr, 22'h3FFFFF);
        do_ack();
        chk("t5_wrap", req_addr, 22'h000000);
        do_data(32'h12345678);
`ifdef GPU_PREFETCH_PC_OUT_EN
        chk("t5_pc", ins_pc, 23'h7FFFFE);
        chk("t5_pc_x", $isunknown(ins_pc), 0);
`endif
        chk("t5_x", $isunknown({req, req_addr, ins_valid, ins_data, busy}), 0);

        // Reset while waiting: late response is ignored.
        do_rst();
        do_jump(23'h0);
        idle();
        do_ack();
        do_rst();
        chk("t6_req", req, 0);
        chk("t6_valid", ins_valid, 0);
        do_data(32'hCAFEF00D);
        chk("t6_nopush", ins_valid, 0);

        // Random traffic with alternating drain rates.
        for (int i = 0; i < 4000; i++) begin
            bit          r, j, a, rv, rdy;
            logic [22:0] ja;
            logic [31:0] rd;
            r   = ($urandom_range(199) != 0);
            j   = ($urandom_range(19) == 0);
            ja  = ($urandom_range(3) == 0) ? 23'h7FFFFC + 23'($urandom_range(3)) : 23'($urandom);
            a   = m_reqing ? bit'($urandom_range(1)) : ($urandom_range(9) == 0);
            rv  = m_waiting ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
            rd  = $urandom;
            rdy = ((i / 400) % 2 == 1) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 8);
            cyc(r, j, ja, a, rv, rd, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
